// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr), BITS_PER_CYCLE op2 bits per BUSY cycle.
// Define HARDISC_CLMUL_EARLY_EXIT_EN to finish as soon as the remaining op2 bits are all zero.
module clmul_unit #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [1:0]  s_mode_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  input  logic        s_flush_i,
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic [31:0] s_result_o
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic [1:0]    mode_q, mode_d;
  logic [63:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   result_q, result_d;

  logic          accept;
  logic          last_chunk;
  logic [63:0]   acc_step;
  logic [31:0]   op2_rest;

  // op1 is kept pre-shifted by the chunk offset, so bit j of the chunk is absolute bit k.
  always_comb begin
    acc_step = acc_q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (op2_q[j]) begin
        acc_step = acc_step ^ (op1_q << j);
      end
    end
  end

  assign op2_rest = 32'({32'b0, op2_q} >> BITS_PER_CYCLE);

`ifdef HARDISC_CLMUL_EARLY_EXIT_EN
  assign last_chunk = (cnt_q == CW'(N - 1)) || (op2_rest == 32'b0);
`else
  assign last_chunk = (cnt_q == CW'(N - 1));
`endif

  assign accept = s_valid_i & s_ready_o;

  function automatic logic [31:0] select_result(input logic [63:0] acc, input logic [1:0] mode);
    case (mode)
      2'b00:   select_result = acc[31:0];
      2'b01:   select_result = acc[63:32];
      2'b10:   select_result = acc[62:31];
      default: select_result = 32'b0;
    endcase
  endfunction

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (s_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A kill wins over both handshakes.
    if (s_flush_i) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    s_ready_o  = (state_q == IDLE) & ~s_flush_i & ~s_rst_i;
    s_valid_o  = (state_q == DONE);
    s_result_o = result_q;
  end

  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      op1_d  = {32'b0, s_op1_i};
      op2_d  = s_op2_i;
      mode_d = s_mode_i;
      acc_d  = 64'b0;
      cnt_d  = '0;
    end else if ((state_q == BUSY) && !s_flush_i) begin
      acc_d = acc_step;
      op1_d = op1_q << BITS_PER_CYCLE;
      op2_d = op2_rest;
      if (last_chunk) begin
        result_d = select_result(acc_step, mode_q);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      op1_q    <= 64'b0;
      op2_q    <= 32'b0;
      mode_q   <= 2'b0;
      acc_q    <= 64'b0;
      cnt_q    <= '0;
      result_q <= 32'b0;
    end else begin
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_clmul_unit.sv
// Scoreboard bench for clmul_unit: three instances (BITS_PER_CYCLE 4, 1, 32) share one expected queue.
module tb_clmul_unit;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  vld_i;
  logic [2:0]  flush;
  logic [2:0]  rdy_i;
  logic [1:0]  mode [3];
  logic [31:0] op1 [3];
  logic [31:0] op2 [3];
  logic [2:0]  rdy_o;
  logic [2:0]  vld_o;
  logic [31:0] res [3];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb[$];

  clmul_unit #(.BITS_PER_CYCLE(4)) u_dut (
    .s_clk_i(clk), .s_rst_i(rst[0]), .s_valid_i(vld_i[0]), .s_ready_o(rdy_o[0]),
    .s_mode_i(mode[0]), .s_op1_i(op1[0]), .s_op2_i(op2[0]), .s_flush_i(flush[0]),
    .s_valid_o(vld_o[0]), .s_ready_i(rdy_i[0]), .s_result_o(res[0])
  );

  clmul_unit #(.BITS_PER_CYCLE(1)) u_dut_b1 (
    .s_clk_i(clk), .s_rst_i(rst[1]), .s_valid_i(vld_i[1]), .s_ready_o(rdy_o[1]),
    .s_mode_i(mode[1]), .s_op1_i(op1[1]), .s_op2_i(op2[1]), .s_flush_i(flush[1]),
    .s_valid_o(vld_o[1]), .s_ready_i(rdy_i[1]), .s_result_o(res[1])
  );

  clmul_unit #(.BITS_PER_CYCLE(32)) u_dut_b32 (
    .s_clk_i(clk), .s_rst_i(rst[2]), .s_valid_i(vld_i[2]), .s_ready_o(rdy_o[2]),
    .s_mode_i(mode[2]), .s_op1_i(op1[2]), .s_op2_i(op2[2]), .s_flush_i(flush[2]),
    .s_valid_o(vld_o[2]), .s_ready_i(rdy_i[2]), .s_result_o(res[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int bpc_of(input int d);
    case (d)
      1:       return 1;
      2:       return 32;
      default: return 4;
    endcase
  endfunction

  // Cycles from the accept cycle to the first cycle with s_valid_o high.
  function automatic int exp_lat(input logic [31:0] b, input int bpc);
`ifdef HARDISC_CLMUL_EARLY_EXIT_EN
    int msb;
    int l;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    if (msb < 0) return 2;
    l = 1 + (msb + bpc) / bpc;
    return (l < 2) ? 2 : l;
`else
    return 32 / bpc + 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Monitor: pops the entry for a DUT on the first cycle of each valid result.
  logic [2:0] vld_prev = 3'b0;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vld_o[d] === 1'b1 && vld_prev[d] !== 1'b1) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].id == d) idx = i;
        end
        if (idx < 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid dut%0d: got result %h, expected no output", d, res[d]);
        end else begin
          chk($sformatf("result dut%0d", d), res[d], sb[idx].res);
          chk($sformatf("latency dut%0d", d), 32'(cyc - sb[idx].t_acc), 32'(sb[idx].lat));
          sb.delete(idx);
        end
      end
    end
    vld_prev = vld_o;
  end

  // Present a request and hold it until accepted; operands are scrambled afterwards.
  task automatic issue(input int d, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input bit push,
                       output int t_acc);
    bit got;
    got   = 1'b0;
    t_acc = 0;
    op1[d] = a; op2[d] = b; mode[d] = m; vld_i[d] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rdy_o[d] === 1'b1) begin
        got   = 1'b1;
        t_acc = cyc;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got no s_ready_o, expected accept", d);
    end else if (push) begin
      sb.push_back('{d, expv, exp_lat(b, bpc_of(d)), t_acc});
    end
    @(posedge clk);
    #1;
    vld_i[d] = 1'b0;
    op1[d] = $urandom; op2[d] = $urandom; mode[d] = 2'($urandom);
  endtask

  task automatic wait_done(input int d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vld_o[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout dut%0d: got no s_valid_o, expected a result", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int d, input logic [1:0] m, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] expv);
    int t;
    issue(d, m, a, b, expv, 1'b1, t);
    wait_done(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit seen;
    rst = 3'b111; vld_i = 3'b0; flush = 3'b0; rdy_i = 3'b111;
    for (int d = 0; d < 3; d++) begin
      mode[d] = 2'b0; op1[d] = 32'b0; op2[d] = 32'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid dut%0d", d), 32'(vld_o[d]), 32'd0);
      chk($sformatf("reset_result dut%0d", d), res[d], 32'd0);
      chk($sformatf("reset_ready dut%0d", d), 32'(rdy_o[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 3'b000;

    run(0, 2'b00, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005);
    run(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run(0, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555);
    run(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555);
    run(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run(0, 2'b00, 32'h0000_0001, 32'h0000_0010, 32'h0000_0010);
    run(0, 2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000);
    run(0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    run(0, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0003);
    run(0, 2'b00, 32'h1234_5678, 32'h0000_0001, 32'h1234_5678);

    run(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555);
    run(1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555);
    run(2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555);
    run(2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555);

    // Backpressure: consumer stalls for 5 cycles after the result appears.
    rdy_i[0] = 1'b0;
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1, t);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vld_o[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bp_timeout: got no s_valid_o, expected a result");
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 32'(vld_o[0]), 32'd1);
      chk("bp_result_held", res[0], 32'h5555_5555);
      chk("bp_ready_low", 32'(rdy_o[0]), 32'd0);
      @(negedge clk);
    end
    rdy_i[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(vld_o[0]), 32'd0);
    chk("bp_release_ready", 32'(rdy_o[0]), 32'd1);
    @(posedge clk);
    #1;

    // Flush at T+4 with a competing request in the same cycle.
    issue(0, 2'b00, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005, 1'b0, t);
    repeat (3) @(posedge clk);
    #1;
    flush[0] = 1'b1;
    vld_i[0] = 1'b1; op1[0] = 32'h0000_0007; op2[0] = 32'h0000_0007; mode[0] = 2'b00;
    @(negedge clk);
    chk("flush_ready_low", 32'(rdy_o[0]), 32'd0);
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    vld_i[0] = 1'b0;
    @(negedge clk);
    chk("flush_ready_t5", 32'(rdy_o[0]), 32'd1);
    chk("flush_no_valid", 32'(vld_o[0]), 32'd0);
    repeat (12) @(posedge clk);
    #1;

    // Reset at T+3, held two cycles; all outputs low once it has taken effect.
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, t);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rst_ready_comb", 32'(rdy_o[0]), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 32'(vld_o[0]), 32'd0);
    chk("rst_result", res[0], 32'd0);
    chk("rst_ready", 32'(rdy_o[0]), 32'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    run(0, 2'b00, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clmul_unit.md
# clmul_unit

Iterative carry-less multiplier for the Zbc operations `clmul`, `clmulh` and `clmulr`. It sits beside the bit-manipulation execution unit in the executor and receives the same operands. Its result is returned into the executor result path through a valid/ready handshake. The unit processes `BITS_PER_CYCLE` bits of op2 per cycle, trading latency for area, so that the single-cycle combinational path stays short.

## Interface
- `BITS_PER_CYCLE`, default 4: op2 bits consumed per BUSY cycle. Legal values are 1, 2, 4, 8, 16 and 32. N = 32/BITS_PER_CYCLE.
- `s_clk_i` input, 1 bit: clock.
- `s_rst_i` input, 1 bit: reset, synchronous and active-high.
- `s_valid_i` input, 1 bit: a request is present.
- `s_ready_o` output, 1 bit: the unit can accept a request.
- `s_mode_i` input, 2 bits: 00 = clmul, 01 = clmulh, 10 = clmulr, 11 = reserved.
- `s_op1_i` input, 32 bits: multiplicand (rs1).
- `s_op2_i` input, 32 bits: multiplier (rs2).
- `s_flush_i` input, 1 bit: abort any in-flight operation (pipeline kill).
- `s_valid_o` output, 1 bit: the result is valid.
- `s_ready_i` input, 1 bit: the consumer accepts the result.
- `s_result_o` output, 32 bits: the result, held stable while `s_valid_o` is high.

## Operation
- **States.** The unit has three states: IDLE, BUSY and DONE.
- **Ready.** `s_ready_o` = (state == IDLE) & ~`s_flush_i` & ~`s_rst_i`.
- **Input handshake.** When `s_valid_i` & `s_ready_o`:
  - latch op1, op2 and mode;
  - clear the 64-bit accumulator `acc` and the chunk counter;
  - go to BUSY.
- **BUSY, each cycle.** For each of the `BITS_PER_CYCLE` bits j of the current op2 chunk (LSB first, absolute index k):
  - if op2[k] = 1, then `acc` ^= zero-extended op1 << k;
  - then shift the remaining op2 right by `BITS_PER_CYCLE`;
  - then increment the counter.
- **Leaving BUSY.** After the N-th chunk, go to DONE and register `s_result_o`.
- **Result selection:**
  - clmul = `acc`[31:0];
  - clmulh = `acc`[63:32];
  - clmulr = `acc`[62:31];
  - reserved mode = 0x00000000, with normal latency.
- **DONE.** `s_valid_o` = 1 and `s_result_o` is held. On `s_ready_i`, go to IDLE. A new request is accepted no earlier than the following cycle; there is no same-cycle bypass.
- **Flush.** `s_flush_i` in any state gives IDLE next cycle.
  - `s_valid_o` drops next cycle and the result is discarded.
  - Flush overrides a same-cycle input handshake (`s_ready_o` is 0) and a same-cycle output handshake.
- **Input stability.** Operand and mode inputs are ignored outside the accept cycle.
- **Reset.** While `s_rst_i` is high:
  - state = IDLE;
  - `s_valid_o` = 0, `s_result_o` = 0, `s_ready_o` = 0;
  - `acc`, the counter and latched operands are cleared.
  Reset mid-operation abandons the operation with no output.

## Timing
- Request accepted at cycle T. BUSY occupies cycles T+1 to T+N. `s_valid_o` rises at T+N+1.
- With the default parameter (N = 8), the result is valid at T+9.
- The result is held for as long as `s_ready_i` is low.
- Minimum request spacing is N+2 cycles, when `s_ready_i` is tied high.
- Counter width is ceil(log2(N)) bits, with a minimum of 1. There is no wrap-around: the counter terminates at N-1.
- The only combinational paths are `s_ready_o` from state, `s_flush_i` and `s_rst_i`. `s_valid_o` and `s_result_o` are registered.

## Configuration
- **`HARDISC_CLMUL_EARLY_EXIT_EN` defined:**
  - in BUSY, if the op2 bits remaining after the current chunk are all zero, go to DONE next cycle;
  - latency becomes 1 + ceil((msb index of op2 + 1)/`BITS_PER_CYCLE`) cycles to `s_valid_o`, with a minimum of T+2;
  - op2 = 0 gives `s_valid_o` at T+2 with result 0.
- **Undefined:** latency is always N+1, independent of the data. This is the constant-time default.

## Test plan
- **Basic clmul.** clmul with op1 = 0x00000003, op2 = 0x00000003, default parameter. Required: `s_result_o` = 0x00000005, `s_valid_o` high exactly at T+9 with the macro undefined.
- **High and reversed results.** clmulh and clmulr with op1 = op2 = 0x80000000.
  - clmulh → 0x40000000.
  - clmulr → 0x80000000.
- **All-ones operands.** op1 = op2 = 0xFFFFFFFF.
  - clmul → 0x55555555.
  - clmulh → 0x55555555.
  - Repeat with `BITS_PER_CYCLE` = 1 and = 32: identical results, with valid at T+33 and T+2 respectively.
- **Backpressure.** Hold `s_ready_i` low for 5 cycles after valid. Required: `s_result_o` and `s_valid_o` stable and `s_ready_o` = 0 throughout; IDLE one cycle after `s_ready_i` rises.
- **Flush and reset mid-operation.**
  - Assert `s_flush_i` at T+4, with `s_valid_i` high in the same cycle: no `s_valid_o` ever appears for that request and the same-cycle request is not accepted. `s_ready_o` = 1 at T+5.
  - Assert `s_rst_i` at T+3: all outputs are 0 the next cycle.
- **Early exit (macro defined).** op2 = 0x00000000 → result 0 and valid at T+2. op2 = 0x00000010, op1 = 0x1 → result 0x10 and valid at T+3.
